seq_bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector FSMs, such as the overlapping 1010 Moore detector. It accepts DATA_W-bit words over a valid/ready handshake and emits one bit per clock on x, which drives the detector's serial input directly. Back-to-back words stream with no idle gap, so patterns that span word boundaries are still detected downstream.

---
 rtl/seq_ser_pkg.sv | 35 +++
 rtl/ser_shift_reg.sv | 50 +++++
 rtl/seq_bit_serializer.sv | 137 +++++++++++++
 tb/tb_seq_bit_serializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_ser_pkg
// Purpose : Shared types and sizing helpers for the bit serializer.
//           - ser_state_t : FSM state encoding (IDLE / SHIFT)
//           - frame_len() : serial frame length in bits for a word width
//           - cnt_width() : bit-counter width for a word width
// Config  : SER_PARITY_EN (define to append an even-parity bit per frame)
// Revision: 1.0 - initial release
// ============================================================================
package seq_ser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

`ifdef SER_PARITY_EN
  localparam bit c_PARITY_EN = 1'b1;
`else
  localparam bit c_PARITY_EN = 1'b0;
`endif

  // Number of serial bits emitted per accepted word.
  function automatic int frame_len(input int data_w);
    return data_w + (c_PARITY_EN ? 1 : 0);
  endfunction

  // Wide enough to hold LAST in both the plain and the parity build.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : ser_shift_reg
// Purpose : Parameterised load/shift register with a direction select.
//           The head bit is the next bit to be sent on the serial line.
// Ports   : clk     - rising-edge clock
//           rst_n   - asynchronous active-low reset (clears the register)
//           i_load  - load i_data (has priority over i_shift)
//           i_shift - shift one position toward the head, zero fill
//           i_data  - parallel load value
//           o_head  - current head bit (MSB if MSB_FIRST, else LSB)
// Revision: 1.0 - initial release
// ============================================================================
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      assign o_head    = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      assign o_head    = r_sr[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= w_shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : seq_bit_serializer
// Purpose : Parallel-to-serial front end for serial sequence detectors.
//           Accepts DATA_W-bit words on a valid/ready handshake and emits
//           one bit per clock on x. Back-to-back words stream with no gap.
// Ports   : clk      - rising-edge clock
//           rst_n    - asynchronous active-low reset
//           in_data  - parallel word to serialize
//           in_valid - in_data is valid
//           in_ready - a word can be accepted this cycle (register decode)
//           x        - serial bit (0 while idle)
//           x_valid  - x carries a frame bit this cycle
//           busy     - a frame is being shifted
//           done     - high while the last bit of a frame is on x
// Config  : SER_PARITY_EN - when defined, each frame carries one extra
//           even-parity bit (XOR of the word) after the data bits.
// Revision: 1.0 - initial release
// ============================================================================
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int              FRAME_W = frame_len(DATA_W);
  localparam int              CNT_W   = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FRAME_W - 1);

  ser_state_t         r_state;
  ser_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last;
  logic               w_accept;
  logic               w_load;
  logic               w_shift;
  logic               w_head;
  logic [FRAME_W-1:0] w_frame;

  // Frame image as loaded into the shift register. With parity, the parity
  // bit sits on the far side from the head so it leaves after the data.
`ifdef SER_PARITY_EN
  generate
    if (MSB_FIRST) begin : g_par_msb
      assign w_frame = {in_data, ^in_data};
    end else begin : g_par_lsb
      assign w_frame = {^in_data, in_data};
    end
  endgenerate
`else
  assign w_frame = in_data;
`endif

  ser_shift_reg #(
    .WIDTH     (FRAME_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_frame),
    .o_head  (w_head)
  );

  assign w_last = (r_state == ST_SHIFT) && (r_cnt == c_LAST);

  // Ready depends only on registers, so a new word can be taken on the
  // same edge that retires the last bit (zero-bubble streaming).
  assign in_ready = (r_state == ST_IDLE) || w_last;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_shift     = 1'b1;
          end
        end else begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // All outputs decode directly from state registers, so they change only
  // on the clock edge and are mutually aligned with x.
  assign busy    = (r_state == ST_SHIFT);
  assign x_valid = busy;
  assign x       = busy && w_head;
  assign done    = w_last;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_bit_serializer
// Purpose : Self-checking bench for seq_bit_serializer. One MSB-first and
//           one LSB-first instance share the same stimulus; a queue-based
//           reference model predicts every output cycle by cycle.
// Config  : SER_PARITY_EN (frame length and expected bit images follow it)
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_bit_serializer;

  localparam int DATA_W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam logic [31:0] EXP_AA_M  = 32'h154;
  localparam logic [31:0] EXP_AA_L  = 32'h0AA;
  localparam logic [31:0] EXP_B2B_M = 32'h29478;
  localparam logic [31:0] EXP_B2B_L = 32'h29478;
  localparam logic [31:0] EXP_07_M  = 32'h00F;
  localparam logic [31:0] EXP_07_L  = 32'h1C1;
`else
  localparam bit PAR = 1'b0;
  localparam logic [31:0] EXP_AA_M  = 32'hAA;
  localparam logic [31:0] EXP_AA_L  = 32'h55;
  localparam logic [31:0] EXP_B2B_M = 32'hA53C;
  localparam logic [31:0] EXP_B2B_L = 32'hA53C;
  localparam logic [31:0] EXP_07_M  = 32'h07;
  localparam logic [31:0] EXP_07_L  = 32'hE0;
`endif
  localparam int FRAME_LEN = DATA_W + (PAR ? 1 : 0);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;

  logic m_ready, m_x, m_xv, m_busy, m_done;
  logic l_ready, l_x, l_xv, l_busy, l_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining bits of the frame currently on the line.
  bit qm[$];
  bit ql[$];

  // Tallies for directed scenarios.
  logic [63:0] acc_m, acc_l;
  int n_xv, n_busy, n_done, done_at;

  always #5 clk = ~clk;

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .x(m_x), .x_valid(m_xv), .busy(m_busy), .done(m_done)
  );

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .x(l_x), .x_valid(l_xv), .busy(l_busy), .done(l_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    bit ex_m, ex_l;
    ex_m = (qm.size() > 0) ? qm[0] : 1'b0;
    ex_l = (ql.size() > 0) ? ql[0] : 1'b0;
    check_eq({ph, " msb x"},        32'(m_x),     32'(ex_m));
    check_eq({ph, " msb x_valid"},  32'(m_xv),    32'(qm.size() > 0));
    check_eq({ph, " msb busy"},     32'(m_busy),  32'(qm.size() > 0));
    check_eq({ph, " msb done"},     32'(m_done),  32'(qm.size() == 1));
    check_eq({ph, " msb in_ready"}, 32'(m_ready), 32'(qm.size() <= 1));
    check_eq({ph, " lsb x"},        32'(l_x),     32'(ex_l));
    check_eq({ph, " lsb x_valid"},  32'(l_xv),    32'(ql.size() > 0));
    check_eq({ph, " lsb busy"},     32'(l_busy),  32'(ql.size() > 0));
    check_eq({ph, " lsb done"},     32'(l_done),  32'(ql.size() == 1));
    check_eq({ph, " lsb in_ready"}, 32'(l_ready), 32'(ql.size() <= 1));
  endtask

  // One clock of the model: the head bit leaves; if a word is offered while
  // at most one bit remains, its whole frame is queued behind it.
  task automatic model_step(input logic v, input logic [DATA_W-1:0] d);
    bit rdy_m, rdy_l;
    rdy_m = (qm.size() <= 1);
    rdy_l = (ql.size() <= 1);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (v && rdy_m) begin
      for (int i = DATA_W - 1; i >= 0; i--) qm.push_back(d[i]);
      if (PAR) qm.push_back(^d);
    end
    if (v && rdy_l) begin
      for (int i = 0; i < DATA_W; i++) ql.push_back(d[i]);
      if (PAR) ql.push_back(^d);
    end
  endtask

  task automatic clear_tally();
    acc_m = '0; acc_l = '0;
    n_xv = 0; n_busy = 0; n_done = 0; done_at = -1;
  endtask

  task automatic tally();
    if (m_xv === 1'b1) begin
      acc_m = {acc_m[62:0], m_x};
      acc_l = {acc_l[62:0], l_x};
      n_xv++;
    end
    if (m_busy === 1'b1) n_busy++;
    if (m_done === 1'b1) begin
      n_done++;
      done_at = n_xv;
    end
  endtask

  // Called just after a falling edge: drive inputs, advance the model,
  // let the rising edge happen, then check at the next falling edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input string ph);
    in_valid = v;
    in_data  = d;
    model_step(v, d);
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
    tally();
  endtask

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_outputs("reset");
    repeat (2) @(negedge clk);
    check_outputs("reset_hold");
    rst_n = 1'b1;

    // Stall at idle
    clear_tally();
    repeat (20) cycle(1'b0, DATA_W'($urandom), "idle");
    check_eq("idle x_valid count", n_xv, 0);
    check_eq("idle done count", n_done, 0);

    // Single word 8'hAA
    clear_tally();
    cycle(1'b1, 8'hAA, "aa");
    repeat (FRAME_LEN + 3) cycle(1'b0, DATA_W'($urandom), "aa");
    check_eq("aa msb bits", acc_m[31:0], EXP_AA_M);
    check_eq("aa lsb bits", acc_l[31:0], EXP_AA_L);
    check_eq("aa x_valid count", n_xv, FRAME_LEN);
    check_eq("aa done count", n_done, 1);
    check_eq("aa done position", done_at, FRAME_LEN);

    // Back-to-back 8'hA5 then 8'h3C with in_valid held high
    clear_tally();
    cycle(1'b1, 8'hA5, "b2b");
    repeat (FRAME_LEN) cycle(1'b1, 8'h3C, "b2b");
    repeat (FRAME_LEN + 3) cycle(1'b0, DATA_W'($urandom), "b2b");
    check_eq("b2b msb bits", acc_m[31:0], EXP_B2B_M);
    check_eq("b2b lsb bits", acc_l[31:0], EXP_B2B_L);
    check_eq("b2b x_valid count", n_xv, 2 * FRAME_LEN);
    check_eq("b2b busy count", n_busy, 2 * FRAME_LEN);
    check_eq("b2b done count", n_done, 2);
    check_eq("b2b last done position", done_at, 2 * FRAME_LEN);

    // Word 8'h07 (odd parity weight)
    clear_tally();
    cycle(1'b1, 8'h07, "w07");
    repeat (FRAME_LEN + 2) cycle(1'b0, DATA_W'($urandom), "w07");
    check_eq("w07 msb bits", acc_m[31:0], EXP_07_M);
    check_eq("w07 lsb bits", acc_l[31:0], EXP_07_L);

    // Reset in the middle of a frame of 8'hFF
    cycle(1'b1, 8'hFF, "midrst");
    cycle(1'b0, 8'h00, "midrst");
    cycle(1'b0, 8'h00, "midrst");
    #2 rst_n = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_outputs("midrst asserted");
    @(negedge clk);
    check_outputs("midrst held");
    rst_n = 1'b1;
    clear_tally();
    repeat (FRAME_LEN + 2) cycle(1'b0, 8'h00, "midrst after");
    check_eq("midrst leftover bits", n_xv, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(3) != 0), DATA_W'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
